// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one UART transmitter between NUM_REQ byte streams.
// A grant is held from the first byte until the packet's last byte or MAX_PKT bytes have been sent.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_PKT      = 64,
  parameter int BUSY_TIMEOUT = 16,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active,
  output logic [1:0]           state_dbg
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic            active_q, active_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            last_q, last_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [ID_W-1:0] winner;
  int              idx;

  // Handshake: a byte moves when req_valid[i] and req_ready[i] are both high at a rising
  // edge; req_valid must then hold (with stable data/last) until that edge occurs.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    active_d   = active_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    last_d     = last_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    req_ready  = '0;
    winner     = ptr_q;
    idx        = 0;

    // Scan downward so the requester closest above the pointer is assigned last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[ID_W'(idx)]) winner = ID_W'(idx);
    end

    case (state_q)
      S_IDLE: begin
        if ((|req_valid) && !tx_busy) begin
          grant_d  = winner;
          active_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (req_valid[grant_q] && !tx_busy) begin
          req_ready[grant_q] = 1'b1;
          tx_start_d         = 1'b1;
          tx_data_d          = req_data[{grant_q, 3'b000} +: 8];
          last_d             = req_last[grant_q];
          cnt_d              = cnt_q + 8'd1;
          to_d               = '0;
          state_d            = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        // The count includes the tx_start cycle itself.
        to_d = to_q + TO_W'(1);
        if (tx_busy || (to_q == TO_W'(BUSY_TIMEOUT - 1))) state_d = S_WAIT_LO;
      end
      default: begin
        if (!tx_busy) begin
          if (last_q || (cnt_q == 8'(MAX_PKT))) begin
            active_d = 1'b0;
            ptr_d    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      active_q   <= 1'b0;
      cnt_q      <= '0;
      to_q       <= '0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      last_q     <= last_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_q;
  assign active    = active_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte sources, a UART busy model, and a packet-level
// reference model that predicts grant order and the byte stream seen at tx_start.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int MAXP = 4;
  localparam int BTO  = 16;
  localparam int DEPTH = 512;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           active;
  logic [1:0]     state_dbg;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_PKT(MAXP), .BUSY_TIMEOUT(BTO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int start_log[$];
  int grant_log[$];

  logic [7:0] src_data [N][DEPTH];
  logic       src_last [N][DEPTH];
  int         src_gap  [N][DEPTH];
  int         wr [N] = '{default: 0};
  int         rd [N] = '{default: 0};
  int         gap_left [N] = '{default: 0};
  bit         gap_loaded [N] = '{default: 1'b0};
  bit         flush = 1'b0;

  bit mute = 1'b0;
  int fixed_len = 10;
  int busy_left = 0;

  int         m_ptr = 0;
  int         m_gid = 0;
  int         m_cnt = 0;
  bit         m_granted = 1'b0;
  logic [N-1:0] prev_valid = '0;
  logic       prev_active = 1'b0;
  int         last_acc_cyc = -10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int gl(input int k);
    return (k < grant_log.size()) ? grant_log[k] : -1;
  endfunction

  function automatic int sl(input int k);
    return (k < start_log.size()) ? start_log[k] : -1000;
  endfunction

  task automatic load(input int i, input logic [7:0] d, input logic l, input int g);
    src_data[i][wr[i]] = d;
    src_last[i][wr[i]] = l;
    src_gap[i][wr[i]]  = g;
    wr[i]++;
  endtask

  // Source drivers: hold each byte until accepted, optional idle gap before each byte.
  initial begin
    logic [N-1:0] acc_d;
    forever begin
      @(negedge clk);
      acc_d = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (flush) begin
          rd[i] = wr[i];
          gap_loaded[i] = 1'b0;
          req_valid[i] = 1'b0;
        end else begin
          if (acc_d[i]) begin
            rd[i]++;
            gap_loaded[i] = 1'b0;
            req_valid[i] = 1'b0;
          end
          if (!req_valid[i] && rd[i] < wr[i]) begin
            if (!gap_loaded[i]) begin
              gap_left[i] = src_gap[i][rd[i]];
              gap_loaded[i] = 1'b1;
            end
            if (gap_left[i] > 0) gap_left[i]--;
            else begin
              req_valid[i] = 1'b1;
              req_data[8*i +: 8] = src_data[i][rd[i]];
              req_last[i] = src_last[i][rd[i]];
            end
          end
        end
      end
      flush = 1'b0;
    end
  end

  // UART model: busy from the tx_start cycle for a fixed or random length, or never when muted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_start && !mute) busy_left = (fixed_len > 0) ? fixed_len : $urandom_range(2, 8);
      if (busy_left > 0) begin
        tx_busy = 1'b1;
        busy_left--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor and reference model.
  initial begin
    logic [N-1:0] acc;
    logic [7:0]   e;
    int           w;
    int           j;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_ptr = 0;
        m_granted = 1'b0;
        exp_q.delete();
        prev_active = 1'b0;
      end else begin
        if (tx_start) begin
          start_log.push_back(cyc);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_start_unexpected: got tx_data=%02h, required no start (cycle %0d)", tx_data, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_data, e);
            chk("start_latency", cyc, last_acc_cyc + 1);
          end
        end
        if (req_ready != '0) begin
          chk("ready_onehot", 32'($onehot(req_ready)), 1);
          chk("ready_without_valid", req_ready & ~req_valid, 0);
          acc = req_ready & req_valid;
          for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
              if (!m_granted) begin
                w = -1;
                for (int s = 0; s < N; s++) begin
                  j = (m_ptr + s) % N;
                  if (w < 0 && prev_valid[j]) w = j;
                end
                chk("rr_winner", i, w);
                chk("grant_latency", prev_active, 0);
                m_granted = 1'b1;
                m_gid = i;
                m_cnt = 0;
                grant_log.push_back(i);
              end else begin
                chk("grant_hold", i, m_gid);
              end
              chk("grant_id", grant_id, i);
              chk("active_at_accept", active, 1);
              chk("busy_at_accept", tx_busy, 0);
              exp_q.push_back(src_data[i][rd[i]]);
              last_acc_cyc = cyc;
              m_cnt++;
              if (src_last[i][rd[i]] || m_cnt == MAXP) begin
                m_granted = 1'b0;
                m_ptr = (i + 1) % N;
              end
            end
          end
        end
        prev_active = active;
      end
      prev_valid = req_valid;
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k;
    k = 0;
    while (start_log.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (start_log.size() < n) chk("wait_starts_timeout", start_log.size(), n);
  endtask

  task automatic wait_drain(input int budget);
    int  k;
    bit  done;
    k = 0;
    done = 1'b0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
      done = 1'b1;
      for (int i = 0; i < N; i++) if (rd[i] < wr[i]) done = 1'b0;
      if (exp_q.size() != 0 || active || tx_busy || m_granted) done = 1'b0;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic clear_logs();
    @(posedge clk);
    #2;
    start_log.delete();
    grant_log.delete();
  endtask

  initial begin
    int n;
    int r;
    int len;
    do_reset(3);
    check_reset_values("reset");

    // Single requester, 3-byte packet, busy 10 cycles.
    fixed_len = 10;
    clear_logs();
    load(0, 8'h41, 1'b0, 0);
    load(0, 8'h42, 1'b0, 0);
    load(0, 8'h43, 1'b1, 0);
    wait_starts(3, 300);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy && n < 50);
    chk("t1_active_at_busy_fall", active, 1);
    @(negedge clk);
    chk("t1_active_released", active, 0);
    wait_drain(200);
    chk("t1_start_count", start_log.size(), 3);
    chk("t1_gap01", sl(1) - sl(0), 12);
    chk("t1_gap12", sl(2) - sl(1), 12);
    chk("t1_grant", gl(0), 0);
    // Pointer now 1: requester 1 beats requester 0.
    clear_logs();
    load(0, 8'h50, 1'b1, 0);
    load(1, 8'h51, 1'b1, 0);
    wait_drain(300);
    chk("t1_ptr_first", gl(0), 1);
    chk("t1_ptr_second", gl(1), 0);

    // Requesters 0 and 2 valid together from reset.
    do_reset(1);
    clear_logs();
    load(0, 8'h10, 1'b0, 0);
    load(0, 8'h11, 1'b1, 0);
    load(2, 8'h20, 1'b0, 0);
    load(2, 8'h21, 1'b1, 0);
    wait_drain(400);
    chk("t2_grants", grant_log.size(), 2);
    chk("t2_first", gl(0), 0);
    chk("t2_second", gl(1), 2);

    // Requester 1 goes quiet for 20 cycles mid-packet while requester 3 waits.
    do_reset(1);
    clear_logs();
    load(1, 8'h31, 1'b0, 0);
    load(1, 8'h32, 1'b0, 20);
    load(1, 8'h33, 1'b1, 0);
    load(3, 8'h34, 1'b0, 0);
    load(3, 8'h35, 1'b1, 0);
    wait_drain(500);
    chk("t3_first", gl(0), 1);
    chk("t3_second", gl(1), 3);
    chk("t3_gap_start", sl(1) - sl(0), 21);
    chk("t3_start_count", start_log.size(), 5);

    // MAX_PKT split: 6-byte packet from 0, requester 1 waiting.
    do_reset(1);
    clear_logs();
    for (int b = 0; b < 6; b++) load(0, 8'h60 + 8'(b), (b == 5), 0);
    load(1, 8'h70, 1'b0, 0);
    load(1, 8'h71, 1'b1, 0);
    wait_drain(600);
    chk("t4_grants", grant_log.size(), 3);
    chk("t4_first", gl(0), 0);
    chk("t4_second", gl(1), 1);
    chk("t4_third", gl(2), 0);
    chk("t4_start_count", start_log.size(), 8);

    // Transmitter never goes busy: timeout paces the bytes.
    mute = 1'b1;
    clear_logs();
    load(0, 8'hA0, 1'b0, 0);
    load(0, 8'hA1, 1'b0, 0);
    load(0, 8'hA2, 1'b1, 0);
    wait_drain(400);
    chk("t5_start_count", start_log.size(), 3);
    chk("t5_gap01", sl(1) - sl(0), 18);
    chk("t5_gap12", sl(2) - sl(1), 18);

    // Reset during WAIT_HI.
    clear_logs();
    load(2, 8'h80, 1'b0, 0);
    load(2, 8'h81, 1'b1, 0);
    wait_starts(1, 100);
    repeat (2) @(posedge clk);
    do_reset(1);
    check_reset_values("midreset");
    n = start_log.size();
    repeat (20) @(posedge clk);
    chk("t6_quiet", start_log.size(), n);
    mute = 1'b0;
    clear_logs();
    load(3, 8'h91, 1'b1, 0);
    load(0, 8'h90, 1'b1, 0);
    wait_drain(300);
    chk("t6_first", gl(0), 0);
    chk("t6_second", gl(1), 3);

    // Randomized traffic against the reference model.
    fixed_len = 0;
    for (int batch = 0; batch < 2; batch++) begin
      @(posedge clk);
      #2;
      for (int p = 0; p < 20; p++) begin
        r = $urandom_range(0, N - 1);
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++)
          load(r, 8'($urandom_range(0, 255)), (b == len - 1), $urandom_range(0, 3));
      end
      repeat (150) @(posedge clk);
    end
    wait_drain(20000);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
